// File: rtl/enc_1_act.sv
// Sequential leaky-ReLU over a NUM-element Q8.8 vector, one element per clock.
// Define ENC_1_ACT_CLIP_EN to additionally clip positive results to CLIP_MAX.
module enc_1_act #(
   parameter int                          BITSIZE  = 16,
   parameter int                          NUM      = 6,
   parameter logic signed [BITSIZE-1:0]   CLIP_MAX = 16'sh0600
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BITSIZE*NUM-1:0]   x,
   output logic [BITSIZE*NUM-1:0]   y,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   state_t                    state;
   logic [IW-1:0]             idx;
   logic signed [BITSIZE-1:0] vec_buf [NUM];

   // Negative inputs are scaled by 1/8 via arithmetic shift (floor rounding).
   function automatic logic signed [BITSIZE-1:0] act(input logic signed [BITSIZE-1:0] v);
      logic signed [BITSIZE-1:0] r;
      if (v[BITSIZE-1]) begin
         r = v >>> 3;
      end else begin
`ifdef ENC_1_ACT_CLIP_EN
         r = (v > CLIP_MAX) ? CLIP_MAX : v;
`else
         r = v;
`endif
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         y         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int unsigned i = 0; i < NUM; i++) begin
            vec_buf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int unsigned i = 0; i < NUM; i++) begin
                     vec_buf[i] <= x[BITSIZE*i +: BITSIZE];
                  end
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               y[BITSIZE*int'(idx) +: BITSIZE] <= act(vec_buf[idx]);
               // idx saturates at the last element rather than wrapping.
               if (idx == LAST) begin
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc_1_act.sv
// Scoreboard bench for enc_1_act; honours ENC_1_ACT_CLIP_EN for the clip build.
module tb_enc_1_act;

   localparam int W    = 16;
   localparam int N    = 6;
   localparam int CLIP = 1536;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [W*N-1:0] x = '0;
   logic           in_ready;
   logic [W*N-1:0] y;
   logic           out_valid;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int out_cnt = 0;
   logic [W*N-1:0] sb [$];
   int             out_cyc [$];
   logic [W*N-1:0] sb_exp;

   enc_1_act #(.BITSIZE(W), .NUM(N), .CLIP_MAX(16'sh0600)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .x(x),
      .y(y),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Floor division by 8 for negatives, done arithmetically rather than by shift.
   function automatic logic [W*N-1:0] model(input logic [W*N-1:0] v);
      logic [W*N-1:0]  res;
      logic signed [W-1:0] t;
      int e;
      int r;
      res = '0;
      for (int i = 0; i < N; i++) begin
         t = v[i*W +: W];
         e = t;
         if (e < 0) r = (e - 7) / 8;
         else r = e;
`ifdef ENC_1_ACT_CLIP_EN
         if (r > CLIP) r = CLIP;
`endif
         res[i*W +: W] = r[W-1:0];
      end
      return res;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         if (in_valid && in_ready) sb.push_back(model(x));
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got y=%h, required no pending result", y);
            end else begin
               sb_exp = sb.pop_front();
               if (y !== sb_exp) begin
                  bad++;
                  $display("FAIL sb_result: got y=%h required %h", y, sb_exp);
               end
            end
            out_cnt++;
            out_cyc.push_back(cyc);
         end
      end
   end

   task test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      total++; if (y !== '0) begin bad++; $display("FAIL rst_y: got %h required 0", y); end
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_in_ready: got %b required 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_out_valid: got %b required 0", out_valid); end
   endtask

   task test_basic;
      logic [W*N-1:0] v;
      logic [W*N-1:0] exp_y;
      v = 96'h0000_7FFF_FFFF_8000_FF00_0100;
`ifdef ENC_1_ACT_CLIP_EN
      exp_y = 96'h0000_0600_FFFF_F000_FFE0_0100;
`else
      exp_y = 96'h0000_7FFF_FFFF_F000_FFE0_0100;
`endif
      out_ready = 1'b0;
      in_valid = 1'b1;
      x = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'(k == 6)) begin
            bad++;
            $display("FAIL basic_latency_e%0d: got out_valid=%b required %b", k, out_valid, (k == 6));
         end
      end
      total++; if (y !== exp_y) begin bad++; $display("FAIL basic_y: got %h required %h", y, exp_y); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_hold: got %b required 0", in_ready); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle: got in_ready=%b required 1", in_ready); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_drain: got %0d pending required 0", sb.size()); end
   endtask

   task test_backpressure;
      logic [W*N-1:0] v;
      logic [W*N-1:0] exp_y;
      v = 96'h0250_8001_0007_FFF8_1000_C000;
      exp_y = model(v);
      out_ready = 1'b0;
      in_valid = 1'b1;
      x = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 30 && !out_valid; k++) begin
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: got out_valid=%b required 1", out_valid); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid_%0d: got %b required 1", k, out_valid); end
         total++; if (y !== exp_y) begin bad++; $display("FAIL bp_y_%0d: got %h required %h", k, y, exp_y); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d: got %b required 0", k, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b required 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b required 0", out_valid); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d pending required 0", sb.size()); end
   endtask

   task test_stability;
      int tgt;
      tgt = out_cnt + 1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      x = 96'hF800_0123_FF81_4000_0008_FFF0;
      @(posedge clk); #1;        // E0
      in_valid = 1'b0;
      @(posedge clk);            // E1
      @(posedge clk); #1;        // E2
      x = {N{16'h1234}};
      in_valid = 1'b1;           // must be ignored while running
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 30 && out_cnt < tgt; k++) @(posedge clk);
      #1;
      total++; if (out_cnt != tgt) begin bad++; $display("FAIL stab_timeout: got %0d results required %0d", out_cnt, tgt); end
      repeat (12) @(posedge clk);
      #1;
      total++; if (out_cnt != tgt) begin bad++; $display("FAIL stab_no_extra: got %0d results required %0d", out_cnt, tgt); end
      out_ready = 1'b0;
   endtask

   task test_reset_mid;
      int c0;
      int tgt;
      out_ready = 1'b1;
      in_valid = 1'b1;
      x = 96'h1111_2222_8888_9999_AAAA_3333;
      @(posedge clk); #1;        // E0
      in_valid = 1'b0;
      repeat (3) @(posedge clk); // E1..E3
      #1;
      reset = 1'b1;
      #1;
      total++; if (y !== '0) begin bad++; $display("FAIL rmid_y: got %h required 0", y); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b required 1", in_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      c0 = out_cnt;
      repeat (10) @(posedge clk);
      #1;
      total++; if (out_cnt != c0) begin bad++; $display("FAIL rmid_partial: got %0d results required %0d", out_cnt, c0); end
      tgt = out_cnt + 1;
      in_valid = 1'b1;
      x = 96'h0042_FFC0_0500_8100_0001_FFFE;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 30 && out_cnt < tgt; k++) @(posedge clk);
      #1;
      total++; if (out_cnt != tgt) begin bad++; $display("FAIL rmid_after_timeout: got %0d results required %0d", out_cnt, tgt); end
      out_ready = 1'b0;
   endtask

   task test_back_to_back;
      int c0;
      int n0;
      out_ready = 1'b1;
      c0 = out_cnt;
      n0 = out_cyc.size();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_start_ready: got %b required 1", in_ready); end
      in_valid = 1'b1;
      x = 96'hFFF9_0009_FE01_0000_7000_8008;
      @(posedge clk); #1;
      x = 96'h0001_FFF1_1234_F00F_0600_0601;
      for (int k = 0; k < 30 && !in_ready; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 40 && out_cnt < c0 + 2; k++) @(posedge clk);
      #1;
      total++; if (out_cnt != c0 + 2) begin bad++; $display("FAIL b2b_timeout: got %0d results required %0d", out_cnt - c0, 2); end
      repeat (12) @(posedge clk);
      #1;
      total++; if (out_cnt != c0 + 2) begin bad++; $display("FAIL b2b_count: got %0d results required %0d", out_cnt - c0, 2); end
      if (out_cyc.size() >= n0 + 2) begin
         total++;
         if (out_cyc[n0+1] - out_cyc[n0] != 8) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d cycles required 8", out_cyc[n0+1] - out_cyc[n0]);
         end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending required 0", sb.size()); end
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_stability();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enc_1_act.md
ENC_1_ACT -- requirements
Module: enc_1_act

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, element width, signed two's complement with 8 fractional bits (Q8.8 at default).
REQ-002 SHALL have parameter NUM, default 6, number of vector elements; it matches the 6-element output of the upstream dense layer.
REQ-003 SHALL have parameter CLIP_MAX, default 16'sh0600 (+6.0), upper clip bound, used only when ENC_1_ACT_CLIP_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, high when x is presented.
REQ-007 SHALL have port in_ready, output, 1 bit, high when the block accepts a vector.
REQ-008 SHALL have port x, input, BITSIZE*NUM bits, input vector; element i is x[BITSIZE*i +: BITSIZE].
REQ-009 SHALL have port y, output, BITSIZE*NUM bits, activated vector, with the same element packing as x.
REQ-010 SHALL have port out_valid, output, 1 bit, high when y holds a complete result.
REQ-011 SHALL have port out_ready, input, 1 bit, high when the consumer takes y.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and HOLD; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-013 In IDLE with in_valid=1, the block SHALL capture all of x into an internal buffer at that edge (E0), clear index idx to 0, and enter RUN.
REQ-014 In RUN, at each edge the block SHALL write f(buf[idx]) to y element idx and increment idx; at the edge where idx=NUM-1 it SHALL enter HOLD. With NUM=6 this is edges E1..E6, and out_valid is high from E6.
REQ-015 f(v) SHALL be v for v>=0, and v>>>3 (arithmetic shift, rounding toward minus infinity) for v<0; no multiplier SHALL be used.
REQ-016 Changes on x after E0 SHALL NOT affect the result; in_valid outside IDLE SHALL be ignored.
REQ-017 In HOLD, y and out_valid SHALL stay stable until out_ready=1 is sampled; at that edge the block SHALL return to IDLE.
REQ-018 Back-to-back operation: with out_ready tied high, a new vector SHALL be accepted in the IDLE cycle that follows the handshake edge. This gives a throughput of one vector per NUM+2 cycles.
REQ-019 While in RUN, y elements not yet written SHALL keep their previous values; y is defined only while out_valid=1.
REQ-020 The idx counter SHALL be wide enough for NUM-1 and SHALL NOT wrap beyond NUM-1.

Reset
REQ-021 Reset SHALL force state IDLE, idx=0, buffer=0, y=0, out_valid=0, and in_ready=1 (because the state is IDLE).
REQ-022 Reset asserted in RUN or HOLD SHALL abort the operation immediately; no partial result SHALL be signalled after reset is released.

Configuration
REQ-023 With macro ENC_1_ACT_CLIP_EN defined, f(v) SHALL additionally be clipped to at most CLIP_MAX, giving a leaky ReLU6 behaviour; negative outputs SHALL be unaffected.
REQ-024 With ENC_1_ACT_CLIP_EN undefined, no clip logic SHALL exist, CLIP_MAX SHALL be unused, and f SHALL be exactly as stated in REQ-015.

Verification
REQ-025 Basic transfer: x = {0x0000, 0x7FFF, 0xFFFF, 0x8000, 0xFF00, 0x0100} (element 5 down to element 0) with a one-cycle in_valid -> y = {0x0000, 0x7FFF, 0xFFFF, 0xF000, 0xFFE0, 0x0100}, with out_valid rising 6 edges after capture.
REQ-026 Clip build: the same stimulus with ENC_1_ACT_CLIP_EN defined -> element 4 = 0x0600, and all other elements identical to REQ-025.
REQ-027 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, y is unchanged, and in_ready stays 0; the handshake on the 6th cycle returns the block to IDLE.
REQ-028 Input stability: change x to all 0x1234 at E2 -> the result still matches the vector captured at E0.
REQ-029 Reset mid-RUN: assert reset at E3 -> y=0, out_valid=0 and in_ready=1 at once; a new transfer after reset is released completes correctly.
REQ-030 Back-to-back: out_ready=1 and in_valid=1 held continuously with two distinct vectors -> two results, 8 cycles apart, with no lost or duplicated vector.
